// File: rtl/zigzag_pkg.sv
// zigzag_pkg: shared types and constants for the zigzag scan / quantizer.
// Holds the FSM state enum, the 64-entry zigzag scan table and the level
// saturation limits used by zigzag_qcore and zigzag_quant.
package zigzag_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    CAPT = 2'd2,
    EMIT = 2'd3
  } state_e;

  localparam int LEVEL_W   = 12;
  localparam int RUN_W     = 6;
  localparam int LEVEL_MAX = 2047;
  localparam int LEVEL_MIN = -2048;

  // Scan position k -> raster index n (row in n[5:3], column in n[2:0]).
  localparam logic [5:0] ZZ_TABLE [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  function automatic logic [5:0] zz(input logic [5:0] k);
    return ZZ_TABLE[k];
  endfunction

endpackage

// File: rtl/zigzag_qcore.sv
// zigzag_qcore: combinational quantizer for one coefficient.
// Shift amount grows with the anti-diagonal of the raster index plus the
// global qscale, capped at 15. Division by 2^s truncates toward zero and the
// result is saturated to the signed 12-bit level range.
module zigzag_qcore
  import zigzag_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic [DW-1:0]             q,
  input  logic [5:0]                n,
  input  logic [2:0]                qscale,
  output logic signed [LEVEL_W-1:0] level
);

  // Extra headroom so the rounding bias never overflows the sum.
  localparam int XW = DW + 16;
  localparam logic signed [XW-1:0] ONE    = XW'(1);
  localparam logic signed [XW-1:0] SAT_HI = XW'(LEVEL_MAX);
  localparam logic signed [XW-1:0] SAT_LO = XW'(LEVEL_MIN);

  logic [3:0]             diag;
  logic [3:0]             diag_q4;
  logic [4:0]             s_sum;
  logic [3:0]             s;
  logic signed [XW-1:0]   q_ext;
  logic signed [XW-1:0]   bias;
  logic signed [XW-1:0]   biased;
  logic signed [XW-1:0]   shifted;

  // Shift amount, bias toward zero for negatives, arithmetic shift, saturate.
  always_comb begin
    diag    = {1'b0, n[5:3]} + {1'b0, n[2:0]};
    diag_q4 = diag >> 2;
    s_sum   = {1'b0, diag_q4} + {2'b00, qscale};
    s       = (s_sum > 5'd15) ? 4'd15 : s_sum[3:0];

    q_ext   = {{16{q[DW-1]}}, q};
    bias    = q[DW-1] ? ((ONE <<< s) - ONE) : '0;
    biased  = q_ext + bias;
    shifted = biased >>> s;

    if (shifted > SAT_HI) begin
      level = LEVEL_W'(LEVEL_MAX);
    end else if (shifted < SAT_LO) begin
      level = LEVEL_W'(LEVEL_MIN);
    end else begin
      level = shifted[LEVEL_W-1:0];
    end
  end

endmodule

// File: rtl/zigzag_quant.sv
// zigzag_quant: walks an 8x8 coefficient block in zigzag order from an
// external synchronous RAM, quantizes each value and streams it out with a
// valid/ready handshake.
// Optional feature macro ZIGZAG_QUANT_RLE_EN: when defined, zero levels are
// skipped and counted into the run field, and an end-of-block beat
// {run=0, level=0, last=1} closes the block. When undefined, all 64 levels
// are emitted with run=0 and last on k=63.
module zigzag_quant
  import zigzag_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  output logic          rdy,
  input  logic [5:0]    base,
  input  logic [2:0]    qscale,
  output logic [5:0]    addr,
  input  logic [DW-1:0] q,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [17:0]   out_data,
  output logic          out_last
);

  state_e      state_q, state_d;
  logic [5:0]  k_q, k_d;
  logic [5:0]  base_q, base_d;
  logic [2:0]  qscale_q, qscale_d;
  logic [5:0]  addr_q, addr_d;
  logic [17:0] data_q, data_d;
  logic        last_q, last_d;
  logic [5:0]  k_next;
  logic [5:0]  n;
  logic signed [LEVEL_W-1:0] level;
`ifdef ZIGZAG_QUANT_RLE_EN
  logic [RUN_W-1:0] run_q, run_d;
`endif

  assign n      = zz(k_q);
  assign k_next = k_q + 6'd1;

  zigzag_qcore #(
    .DW(DW)
  ) u_qcore (
    .q      (q),
    .n      (n),
    .qscale (qscale_q),
    .level  (level)
  );

  // Next-state and datapath updates for the scan FSM.
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    base_d   = base_q;
    qscale_d = qscale_q;
    addr_d   = addr_q;
    data_d   = data_q;
    last_d   = last_q;
`ifdef ZIGZAG_QUANT_RLE_EN
    run_d    = run_q;
`endif
    case (state_q)
      IDLE: begin
        if (en) begin
          base_d   = base;
          qscale_d = qscale;
          k_d      = 6'd0;
          addr_d   = base + zz(6'd0);
`ifdef ZIGZAG_QUANT_RLE_EN
          run_d    = '0;
`endif
          state_d  = ADDR;
        end
      end
      ADDR: begin
        // addr_q already holds base + zz(k); RAM data appears next cycle.
        state_d = CAPT;
      end
      CAPT: begin
`ifdef ZIGZAG_QUANT_RLE_EN
        if (level == '0) begin
          if (k_q == 6'd63) begin
            data_d  = '0;
            last_d  = 1'b1;
            run_d   = '0;
            state_d = EMIT;
          end else begin
            run_d   = run_q + 1'b1;
            k_d     = k_next;
            addr_d  = base_q + zz(k_next);
            state_d = ADDR;
          end
        end else begin
          data_d  = {run_q, level};
          last_d  = 1'b0;
          run_d   = '0;
          state_d = EMIT;
        end
`else
        data_d  = {6'd0, level};
        last_d  = (k_q == 6'd63);
        state_d = EMIT;
`endif
      end
      EMIT: begin
        if (out_ready) begin
          if (last_q) begin
            data_d  = '0;
            last_d  = 1'b0;
            state_d = IDLE;
`ifdef ZIGZAG_QUANT_RLE_EN
          end else if (k_q == 6'd63) begin
            // Final nonzero level went out; follow it with end-of-block.
            data_d  = '0;
            last_d  = 1'b1;
`endif
          end else begin
            k_d     = k_next;
            addr_d  = base_q + zz(k_next);
            state_d = ADDR;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, cleared by asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      k_q      <= '0;
      base_q   <= '0;
      qscale_q <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      last_q   <= 1'b0;
`ifdef ZIGZAG_QUANT_RLE_EN
      run_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      base_q   <= base_d;
      qscale_q <= qscale_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      last_q   <= last_d;
`ifdef ZIGZAG_QUANT_RLE_EN
      run_q    <= run_d;
`endif
    end
  end

  assign rdy       = (state_q == IDLE);
  assign out_valid = (state_q == EMIT);
  assign addr      = addr_q;
  assign out_data  = data_q;
  assign out_last  = last_q;

endmodule

// File: tb/tb_zigzag_quant.sv
// tb_zigzag_quant: scoreboard bench for zigzag_quant. Expected beats are
// computed from a behavioural RAM image and an independently generated
// zigzag order, pushed when a block is started and popped per handshake.
// Honours ZIGZAG_QUANT_RLE_EN to pick the expected beat format.
module tb_zigzag_quant;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        rdy;
  logic [5:0]  base;
  logic [2:0]  qscale;
  logic [5:0]  addr;
  logic [15:0] q;
  logic        out_valid;
  logic        out_ready;
  logic [17:0] out_data;
  logic        out_last;

  logic signed [15:0] ram [64];
  logic [18:0] exp_q [$];
  int zz_tb [64];
  int total = 0;
  int bad = 0;
  int ready_mode = 0;
  int beats_seen = 0;

  zigzag_quant #(.DW(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .rdy       (rdy),
    .base      (base),
    .qscale    (qscale),
    .addr      (addr),
    .q         (q),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM model: data follows addr by one cycle.
  always @(posedge clk) q <= ram[addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Consumer ready: 0 = always ready, 1 = random, 2 = held low.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Output monitor: stall stability, scoreboard compare, rdy after last beat.
  initial begin
    logic [18:0] held, got, want;
    bit stalled, last_hs;
    stalled = 0;
    last_hs = 0;
    held = '0;
    forever begin
      @(negedge clk);
      if (last_hs && !reset) check("rdy_after_last", 32'(rdy), 32'd1);
      last_hs = 0;
      if (reset || !out_valid) begin
        stalled = 0;
      end else begin
        got = {out_last, out_data};
        if (stalled) check("stall_hold", 32'(got), 32'(held));
        if (out_ready) begin
          if (exp_q.size() > 0) want = exp_q.pop_front();
          else want = 'x;
          check("beat", {13'd0, got}, {13'd0, want});
          $display("beat %0d run=%0d level=%0d last=%0b", beats_seen,
                   out_data[17:12], $signed(out_data[11:0]), out_last);
          beats_seen++;
          last_hs = out_last;
          stalled = 0;
        end else begin
          stalled = 1;
          held = got;
        end
      end
    end
  end

  // Reference model for one block: push every expected beat.
  task automatic push_expected(input int b, input int qs);
    int n, a, s, lvl;
`ifdef ZIGZAG_QUANT_RLE_EN
    int run;
    run = 0;
`endif
    for (int k = 0; k < 64; k++) begin
      n = zz_tb[k];
      a = ram[(b + n) % 64];
      s = ((n / 8) + (n % 8)) / 4 + qs;
      if (s > 15) s = 15;
      lvl = a / (1 << s);
      if (lvl > 2047) lvl = 2047;
      if (lvl < -2048) lvl = -2048;
`ifdef ZIGZAG_QUANT_RLE_EN
      if (lvl != 0) begin
        exp_q.push_back({1'b0, 6'(run), 12'(lvl)});
        run = 0;
      end else begin
        run++;
      end
`else
      exp_q.push_back({(k == 63), 6'd0, 12'(lvl)});
`endif
    end
`ifdef ZIGZAG_QUANT_RLE_EN
    exp_q.push_back({1'b1, 6'd0, 12'd0});
`endif
  endtask

  task automatic run_block(input int b, input int qs, input bit pulse);
    int cyc;
    push_expected(b, qs);
    cyc = 0;
    while (!rdy && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("rdy_before_start", 32'(rdy), 32'd1);
    en = 1'b1;
    base = 6'(b);
    qscale = 3'(qs);
    @(negedge clk);
    en = 1'b0;
    base = 6'($urandom);
    qscale = 3'($urandom);
    check("busy_after_en", 32'(rdy), 32'd0);
    cyc = 0;
    while (!rdy && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (pulse && cyc == 20) en = 1'b1;
      if (pulse && cyc == 21) en = 1'b0;
    end
    en = 1'b0;
    check("block_done", 32'(rdy), 32'd1);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < 64; i++) ram[i] = 16'(i * 16);
  endtask

  task automatic fill_zero();
    for (int i = 0; i < 64; i++) ram[i] = '0;
  endtask

  initial begin
    int idx, cnt, cyc, r_lo, r_hi;
    reset = 1'b1;
    en = 1'b0;
    base = '0;
    qscale = '0;

    // Zigzag order generated by walking anti-diagonals.
    idx = 0;
    for (int d = 0; d < 15; d++) begin
      r_lo = (d > 7) ? d - 7 : 0;
      r_hi = (d < 7) ? d : 7;
      if (d % 2 == 0) begin
        for (int r = r_hi; r >= r_lo; r--) begin
          zz_tb[idx] = r * 8 + (d - r);
          idx = idx + 1;
        end
      end else begin
        for (int r = r_lo; r <= r_hi; r++) begin
          zz_tb[idx] = r * 8 + (d - r);
          idx = idx + 1;
        end
      end
    end
    fill_zero();

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_addr", 32'(addr), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("rdy_post_reset", 32'(rdy), 32'd1);

    // Ramp block, plain run.
    fill_ramp();
    run_block(0, 0, 0);

    // Negative coefficient truncated toward zero at k=63.
    ram[63] = -16'sd100;
    run_block(0, 1, 0);

    // Saturation at both ends.
    fill_ramp();
    ram[0] = 16'sd32767;
    run_block(0, 0, 0);
    ram[0] = -16'sd32768;
    run_block(0, 0, 0);

    // Sparse block: two nonzero coefficients.
    fill_zero();
    ram[0] = 16'sd5;
    ram[9] = 16'sd40;
    run_block(0, 0, 0);

    // Random back-pressure with an ignored mid-block en.
    fill_ramp();
    ready_mode = 1;
    run_block(0, 0, 1);

    // Random data, wrapping base, nonzero qscale.
    for (int i = 0; i < 64; i++) ram[i] = 16'($urandom);
    run_block(50, 2, 0);
    run_block(13, 7, 0);
    ready_mode = 0;

    // Reset while beat 10 is presented.
    fill_ramp();
    push_expected(0, 0);
    en = 1'b1;
    base = 6'd0;
    qscale = 3'd0;
    @(negedge clk);
    en = 1'b0;
    cnt = 0;
    cyc = 0;
    while (cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (out_valid) begin
        if (cnt == 10) break;
        if (out_ready) cnt++;
      end
    end
    check("reached_beat10", 32'(cnt), 32'd10);
    reset = 1'b1;
    #1;
    check("reset_kills_valid", 32'(out_valid), 32'd0);
    check("reset_addr", 32'(addr), 32'd0);
    check("reset_out_data", 32'(out_data), 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rdy_after_reset", 32'(rdy), 32'd1);
    repeat (5) @(negedge clk);
    check("no_beats_after_reset", 32'(out_valid), 32'd0);
    run_block(0, 0, 0);

    // All-zero block.
    fill_zero();
    run_block(0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/zigzag_quant.md
ZIGZAG_QUANT -- requirements
Module: zigzag_quant

Interface
REQ-001 SHALL have parameter DW, default 16, meaning coefficient word width in RAM.
REQ-002 SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, meaning asynchronous, active-high reset.
REQ-004 SHALL have port en, input, 1, meaning start request, sampled only while rdy=1.
REQ-005 SHALL have port rdy, output, 1, meaning idle and able to accept en.
REQ-006 SHALL have port base, input, 6, meaning RAM offset of the 8x8 block, sampled on the accepted en.
REQ-007 SHALL have port qscale, input, 3, meaning global extra right-shift, sampled on the accepted en.
REQ-008 SHALL have port addr, output, 6, meaning the registered coefficient RAM read address.
REQ-009 SHALL have port q, input, DW, meaning RAM read data, valid on the cycle after the cycle in which addr is presented.
REQ-010 SHALL have port out_valid, output, 1, meaning out_data/out_last hold a beat.
REQ-011 SHALL have port out_ready, input, 1, meaning consumer accepts the beat.
REQ-012 SHALL have port out_data, output, 18, meaning [17:12] run (unsigned), [11:0] level (two's complement).
REQ-013 SHALL have port out_last, output, 1, meaning final beat of the block.

Function
REQ-014 SHALL implement states IDLE, ADDR, CAPT, EMIT, with k (0..63) as the zigzag index.
REQ-015 In IDLE, SHALL assert rdy; on en=1 SHALL latch base and qscale, set k=0, and go to ADDR.
REQ-016 In ADDR, SHALL drive addr = base + zz(k) (6-bit wrap-around), then go to CAPT.
REQ-017 In CAPT, SHALL register the quantized value of q, then go to EMIT, or to ADDR (next k) when the beat is suppressed (REQ-022).
REQ-018 Quantization SHALL be: n = zz(k); s = min(((n[5:3] + n[2:0]) >> 2) + qscale, 15); level = q / 2^s, truncated toward zero (negative q biased by 2^s-1 before the arithmetic shift).
REQ-019 The level SHALL be saturated to [-2048, 2047].
REQ-020 In EMIT, SHALL hold out_valid=1 with out_data and out_last stable until out_ready=1; on the handshake SHALL go to ADDR with k+1, or to IDLE after k=63.
REQ-021 Without the configuration feature, SHALL emit exactly 64 beats with run=0, and SHALL assert out_last on k=63.
REQ-022 With the configuration feature, SHALL emit only nonzero levels, with run = count of zero levels skipped since the previous emitted beat, plus a final end-of-block beat {run=0, level=0, out_last=1} after k=63.
REQ-023 zz(k) SHALL be the standard MPEG-2 zigzag scan (zz(0)=0, zz(1)=1, zz(2)=8, zz(3)=16, ..., zz(63)=63).
REQ-024 An en asserted while rdy=0 SHALL be ignored.
REQ-025 Back-to-back blocks SHALL be allowed: rdy SHALL assert on the cycle after the last handshake.

Reset
REQ-026 While reset=1, SHALL force state=IDLE, k=0, addr=0, out_valid=0, out_data=0, out_last=0, and run=0; rdy SHALL read 1 on the first cycle after reset deasserts.
REQ-027 A reset mid-block SHALL abandon the block with no further beats emitted.

Configuration
REQ-028 Macro ZIGZAG_QUANT_RLE_EN: when defined, SHALL provide the run-length behaviour of REQ-022; when undefined, SHALL provide REQ-021, with no run counter logic present.

Structure
REQ-029 Package zigzag_pkg SHALL hold the state enum, the 64-entry zigzag table constant, and the level saturation limits.
REQ-030 One sub-module, zigzag_qcore, SHALL hold the combinational shift/round/saturate path (inputs q, n, qscale; output level).

Verification
REQ-031 Bench SHALL cover: RAM[i]=i*16, base=0, qscale=0, RLE off, out_ready=1 -> 64 beats, first levels 0, 16, 128; beat k=2 is n=8, s=0, level 128; out_last on beat 64.
REQ-032 Bench SHALL cover: RAM[63]=-100, qscale=1, RLE off -> s=min(3+1,15)=4; beat 64 level = -6 (toward zero, not -7).
REQ-033 Bench SHALL cover: RAM[0]=32767, qscale=0 -> first level 2047 (saturated); RAM[0]=-32768 -> -2048.
REQ-034 Bench SHALL cover: RLE on, only RAM[0]=5 and RAM[9]=40 nonzero (zz index 4, s=0) -> beats {0,5}, {3,40}, {0,0,last}.
REQ-035 Bench SHALL cover: out_ready randomly low 50% -> beats unchanged while stalled, same sequence as REQ-031; en pulsed mid-block is ignored.
REQ-036 Bench SHALL cover: reset asserted during beat 10 -> out_valid=0 immediately; rdy=1 after release; next block is correct.
